vga_config: RTL and testbench



---
 rtl/vga_config.sv | 63 ++++++
 tb/tb_vga_config.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vga_config.sv
// vga_config: register block holding the active VGA timing set; a bus write selects one of three preset modes.
module vga_config #(
  parameter int CONFIG_WIDTH = 4,
  parameter logic [CONFIG_WIDTH-1:0] CONFIG_ADDR = 4'b1011,
  parameter int HL_MARGIN_WIDTH = 8,
  parameter int HR_MARGIN_WIDTH = 6,
  parameter int VL_MARGIN_WIDTH = 6,
  parameter int VR_MARGIN_WIDTH = 4,
  parameter int REZ_MAX_WIDTH = 11,
  parameter int PULSE_WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Valid,
  input  logic [CONFIG_WIDTH-1:0]    Addr,
  input  logic [CONFIG_WIDTH-1:0]    Data,
  output logic                       Load_config,
  output logic [HL_MARGIN_WIDTH-1:0] H_left_margin,
  output logic [HR_MARGIN_WIDTH-1:0] H_right_margin,
  output logic [VL_MARGIN_WIDTH-1:0] V_left_margin,
  output logic [VR_MARGIN_WIDTH-1:0] V_right_margin,
  output logic [REZ_MAX_WIDTH-1:0]   H_count_max,
  output logic [PULSE_WIDTH-1:0]     H_sync_pulse,
  output logic [REZ_MAX_WIDTH-1:0]   V_count_max,
  output logic [PULSE_WIDTH-1:0]     V_sync_pulse
);
  logic                       w_accept;
  logic [1:0]                 w_mode;
  logic [HL_MARGIN_WIDTH-1:0] w_hl;
  logic [HR_MARGIN_WIDTH-1:0] w_hr;
  logic [VL_MARGIN_WIDTH-1:0] w_vl;
  logic [VR_MARGIN_WIDTH-1:0] w_vr;
  logic [REZ_MAX_WIDTH-1:0]   w_hm;
  logic [PULSE_WIDTH-1:0]     w_hs;
  logic [REZ_MAX_WIDTH-1:0]   w_vm;
  logic [PULSE_WIDTH-1:0]     w_vs;
  assign w_accept = Valid && (Addr == CONFIG_ADDR) && (Data[CONFIG_WIDTH-1:2] == '0) && (Data[1:0] != 2'b11);
  // Reset forces the 640x480 table entry through the same load path
  assign w_mode = Rst ? 2'b00 : Data[1:0];
  always_comb begin
    w_hl = w_mode == 2'd2 ? HL_MARGIN_WIDTH'(160)  : w_mode == 2'd1 ? HL_MARGIN_WIDTH'(88)  : HL_MARGIN_WIDTH'(48);
    w_hr = w_mode == 2'd2 ? HR_MARGIN_WIDTH'(24)   : w_mode == 2'd1 ? HR_MARGIN_WIDTH'(40)  : HR_MARGIN_WIDTH'(16);
    w_vl = w_mode == 2'd2 ? VL_MARGIN_WIDTH'(29)   : w_mode == 2'd1 ? VL_MARGIN_WIDTH'(23)  : VL_MARGIN_WIDTH'(33);
    w_vr = w_mode == 2'd2 ? VR_MARGIN_WIDTH'(3)    : w_mode == 2'd1 ? VR_MARGIN_WIDTH'(1)   : VR_MARGIN_WIDTH'(10);
    w_hm = w_mode == 2'd2 ? REZ_MAX_WIDTH'(1343)   : w_mode == 2'd1 ? REZ_MAX_WIDTH'(1055)  : REZ_MAX_WIDTH'(799);
    w_hs = w_mode == 2'd2 ? PULSE_WIDTH'(136)      : w_mode == 2'd1 ? PULSE_WIDTH'(128)     : PULSE_WIDTH'(96);
    w_vm = w_mode == 2'd2 ? REZ_MAX_WIDTH'(805)    : w_mode == 2'd1 ? REZ_MAX_WIDTH'(627)   : REZ_MAX_WIDTH'(524);
    w_vs = w_mode == 2'd2 ? PULSE_WIDTH'(6)        : w_mode == 2'd1 ? PULSE_WIDTH'(4)       : PULSE_WIDTH'(2);
  end
  always_ff @(posedge Clk) begin
    Load_config <= !Rst && w_accept;
    if (Rst || w_accept) begin
      H_left_margin  <= w_hl;
      H_right_margin <= w_hr;
      V_left_margin  <= w_vl;
      V_right_margin <= w_vr;
      H_count_max    <= w_hm;
      H_sync_pulse   <= w_hs;
      V_count_max    <= w_vm;
      V_sync_pulse   <= w_vs;
    end
  end
endmodule

// File: tb/tb_vga_config.sv
// tb_vga_config: directed checks of mode selection, write rejection, reset priority and back-to-back reloads.
module tb_vga_config;
  logic clk = 1'b0;
  logic rst, valid;
  logic [3:0] addr, data;
  logic load_config;
  logic [7:0] h_left;
  logic [5:0] h_right, v_left;
  logic [3:0] v_right;
  logic [10:0] h_max, v_max;
  logic [7:0] h_sync, v_sync;
  logic [61:0] o_all;
  int checks = 0;
  int passes = 0;
  localparam logic [61:0] M0 = {8'd48, 6'd16, 6'd33, 4'd10, 11'd799, 8'd96, 11'd524, 8'd2};
  localparam logic [61:0] M1 = {8'd88, 6'd40, 6'd23, 4'd1, 11'd1055, 8'd128, 11'd627, 8'd4};
  localparam logic [61:0] M2 = {8'd160, 6'd24, 6'd29, 4'd3, 11'd1343, 8'd136, 11'd805, 8'd6};

  vga_config dut (
    .Clk(clk), .Rst(rst), .Valid(valid), .Addr(addr), .Data(data),
    .Load_config(load_config),
    .H_left_margin(h_left), .H_right_margin(h_right),
    .V_left_margin(v_left), .V_right_margin(v_right),
    .H_count_max(h_max), .H_sync_pulse(h_sync),
    .V_count_max(v_max), .V_sync_pulse(v_sync)
  );

  assign o_all = {h_left, h_right, v_left, v_right, h_max, h_sync, v_max, v_sync};
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; addr = 4'd0; data = 4'd0;
    cyc(); cyc();
    checks += 2;
    if (o_all !== M0) $display("FAIL reset_outputs got %h want %h", o_all, M0); else passes++;
    if (load_config !== 1'b0) $display("FAIL reset_load got %b want 0", load_config); else passes++;
    rst = 1'b0;
    cyc();
    checks += 5;
    if (h_max !== 11'd799) $display("FAIL reset_hmax got %0d want 799", h_max); else passes++;
    if (h_sync !== 8'd96) $display("FAIL reset_hsync got %0d want 96", h_sync); else passes++;
    if (v_max !== 11'd524) $display("FAIL reset_vmax got %0d want 524", v_max); else passes++;
    if ({h_left, h_right, v_left, v_right, v_sync} !== {8'd48, 6'd16, 6'd33, 4'd10, 8'd2})
      $display("FAIL reset_margins got %0d/%0d/%0d/%0d vs %0d", h_left, h_right, v_left, v_right, v_sync); else passes++;
    if (load_config !== 1'b0) $display("FAIL release_load got %b want 0", load_config); else passes++;
  endtask

  task automatic test_mode2();
    addr = 4'b1011; data = 4'b0010; valid = 1'b1;
    cyc();
    valid = 1'b0;
    checks += 4;
    if (o_all !== M2) $display("FAIL mode2_outputs got %h want %h", o_all, M2); else passes++;
    if (h_max !== 11'd1343 || h_left !== 8'd160) $display("FAIL mode2_h got %0d/%0d want 1343/160", h_max, h_left); else passes++;
    if (load_config !== 1'b1) $display("FAIL mode2_load got %b want 1", load_config); else passes++;
    cyc();
    if (load_config !== 1'b0) $display("FAIL mode2_load_drop got %b want 0", load_config); else passes++;
  endtask

  task automatic test_valid_low();
    addr = 4'b1011; data = 4'b0000; valid = 1'b0;
    cyc();
    checks += 2;
    if (o_all !== M2) $display("FAIL valid_low_outputs got %h want %h", o_all, M2); else passes++;
    if (load_config !== 1'b0) $display("FAIL valid_low_load got %b want 0", load_config); else passes++;
  endtask

  task automatic test_wrong_addr();
    addr = 4'b1010; data = 4'b0000; valid = 1'b1;
    cyc();
    valid = 1'b0;
    checks += 2;
    if (o_all !== M2) $display("FAIL wrong_addr_outputs got %h want %h", o_all, M2); else passes++;
    if (load_config !== 1'b0) $display("FAIL wrong_addr_load got %b want 0", load_config); else passes++;
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; valid = 1'b0;
    cyc();
    addr = 4'b1011; data = 4'b0001; valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks += 2;
      if (o_all !== M0) $display("FAIL rst_priority_outputs got %h want %h", o_all, M0); else passes++;
      if (load_config !== 1'b0) $display("FAIL rst_priority_load got %b want 0", load_config); else passes++;
    end
    rst = 1'b0; valid = 1'b0;
  endtask

  task automatic test_mode1_reject();
    addr = 4'b1011; data = 4'b0001; valid = 1'b1;
    cyc();
    checks += 3;
    if (o_all !== M1) $display("FAIL mode1_outputs got %h want %h", o_all, M1); else passes++;
    if (h_max !== 11'd1055 || h_sync !== 8'd128 || v_max !== 11'd627 || v_left !== 6'd23)
      $display("FAIL mode1_fields got %0d/%0d/%0d/%0d want 1055/128/627/23", h_max, h_sync, v_max, v_left); else passes++;
    if (load_config !== 1'b1) $display("FAIL mode1_load got %b want 1", load_config); else passes++;
    data = 4'b0011;
    cyc();
    checks += 2;
    if (o_all !== M1) $display("FAIL code11_outputs got %h want %h", o_all, M1); else passes++;
    if (load_config !== 1'b0) $display("FAIL code11_load got %b want 0", load_config); else passes++;
    data = 4'b0100;
    cyc();
    valid = 1'b0;
    checks += 2;
    if (o_all !== M1) $display("FAIL upper_bits_outputs got %h want %h", o_all, M1); else passes++;
    if (load_config !== 1'b0) $display("FAIL upper_bits_load got %b want 0", load_config); else passes++;
  endtask

  task automatic test_back_to_back();
    addr = 4'b1011; data = 4'b0000; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks += 2;
      if (o_all !== M0) $display("FAIL b2b_outputs[%0d] got %h want %h", i, o_all, M0); else passes++;
      if (load_config !== 1'b1) $display("FAIL b2b_load[%0d] got %b want 1", i, load_config); else passes++;
    end
    data = 4'b0010;
    cyc();
    valid = 1'b0;
    checks += 2;
    if (o_all !== M2) $display("FAIL b2b_switch_outputs got %h want %h", o_all, M2); else passes++;
    if (load_config !== 1'b1) $display("FAIL b2b_switch_load got %b want 1", load_config); else passes++;
    cyc();
    checks += 2;
    if (o_all !== M2) $display("FAIL b2b_hold_outputs got %h want %h", o_all, M2); else passes++;
    if (load_config !== 1'b0) $display("FAIL b2b_end_load got %b want 0", load_config); else passes++;
  endtask

  initial begin
    test_reset();
    test_mode2();
    test_valid_low();
    test_wrong_addr();
    test_reset_priority();
    test_mode1_reject();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
